// File: rtl/ex_writeback_arbiter_pkg.sv
// Shared types and constants for the execution-stage writeback arbiter.
package ex_writeback_arbiter_pkg;

  localparam int unsigned FU_LSU   = 0;
  localparam int unsigned FU_FPU   = 1;
  localparam int unsigned FU_INT   = 2;
  localparam int unsigned FU_BR    = 3;
  localparam int unsigned WB_PORTS = 2;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob_tag;
    logic [DATA_W-1:0] data;
  } ex_update;

endpackage

// File: rtl/ex_writeback_arbiter_wb_fu_fifo.sv
// Per-FU result FIFO: DEPTH entries, wrap-bit pointers, synchronous flush.
module wb_fu_fifo
  import ex_writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  ex_update                   din,
  output ex_update                   head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  ex_update    r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_pop  = pop && !w_empty;
  // A full FIFO may still accept a push when its head leaves in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && w_full && !pop && !flush))
    else $error("wb_fu_fifo: push while full, record dropped");

endmodule

// File: rtl/ex_writeback_arbiter.sv
// Two-port round-robin writeback arbiter over per-FU result FIFOs.
// Optional perf counters built only when WB_PERF_CNT_EN is defined.
module ex_writeback_arbiter
  import ex_writeback_arbiter_pkg::*;
#(
  parameter int unsigned FU_NUMBER = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned WB_PORTS  = 2,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  ex_update [FU_NUMBER-1:0]     fu_update,
  output logic     [FU_NUMBER-1:0]     fu_stall,
  output ex_update [WB_PORTS-1:0]      wb_update,
  input  logic                         wb_ready,
  output logic     [CNT_WIDTH-1:0]     perf_conflict_cnt,
  output logic     [CNT_WIDTH-1:0]     perf_stall_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1;

  if (WB_PORTS != 2) begin : g_bad_ports
    $error("ex_writeback_arbiter supports exactly two writeback ports");
  end

  logic [CW-1:0]          w_count    [FU_NUMBER];
  ex_update               w_head     [FU_NUMBER];
  ex_update               w_cand_rec [FU_NUMBER];
  logic [FU_NUMBER-1:0]   w_cand;
  logic [FU_NUMBER-1:0]   w_gnt;
  logic [FU_NUMBER-1:0]   w_push;
  logic [FU_NUMBER-1:0]   w_pop;
  ex_update [WB_PORTS-1:0] w_wb_next;
  ex_update [WB_PORTS-1:0] r_wb;
  logic [PW-1:0]          r_rr_ptr;
  logic [PW-1:0]          w_rr_next;
  logic                   w_grant_en;

  for (genvar gi = 0; gi < FU_NUMBER; gi++) begin : g_fu
    wb_fu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (w_push[gi]),
      .pop   (w_pop[gi]),
      .din   (fu_update[gi]),
      .head  (w_head[gi]),
      .count (w_count[gi])
    );

    // An empty FIFO offers the incoming record directly; it is stored only if not granted.
    assign w_cand[gi]     = (w_count[gi] != '0) || fu_update[gi].valid;
    assign w_cand_rec[gi] = (w_count[gi] != '0) ? w_head[gi] : fu_update[gi];
    assign w_pop[gi]      = w_gnt[gi] && (w_count[gi] != '0);
    assign w_push[gi]     = fu_update[gi].valid && !(w_gnt[gi] && (w_count[gi] == '0));
    assign fu_stall[gi]   = (w_count[gi] == CW'(DEPTH));
  end

  always_comb begin
    int unsigned v_idx;
    logic        v_got0;
    logic        v_got1;
    v_idx      = 0;
    v_got0     = 1'b0;
    v_got1     = 1'b0;
    w_gnt      = '0;
    w_wb_next  = '0;
    w_rr_next  = r_rr_ptr;
    w_grant_en = wb_ready || !(r_wb[0].valid || r_wb[1].valid);
    if (w_grant_en) begin
      for (int unsigned k = 0; k < FU_NUMBER; k++) begin
        v_idx = (32'(r_rr_ptr) + k) % FU_NUMBER;
        if (w_cand[v_idx[PW-1:0]] && !(v_got0 && v_got1)) begin
          w_gnt[v_idx[PW-1:0]] = 1'b1;
          if (!v_got0) begin
            w_wb_next[0]       = w_cand_rec[v_idx[PW-1:0]];
            w_wb_next[0].valid = 1'b1;
            v_got0             = 1'b1;
          end else begin
            w_wb_next[1]       = w_cand_rec[v_idx[PW-1:0]];
            w_wb_next[1].valid = 1'b1;
            v_got1             = 1'b1;
          end
          w_rr_next = PW'((v_idx + 1) % FU_NUMBER);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb     <= '0;
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_wb     <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant_en) begin
      r_wb     <= w_wb_next;
      r_rr_ptr <= w_rr_next;
    end
  end

  assign wb_update = r_wb;

`ifdef WB_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_conflict_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (($countones(w_cand) > 2) && (r_conflict_cnt != '1))
        r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
      if ((|fu_stall) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign perf_conflict_cnt = r_conflict_cnt;
  assign perf_stall_cnt    = r_stall_cnt;
`else
  assign perf_conflict_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_ex_writeback_arbiter.sv
// Scoreboard bench for ex_writeback_arbiter: queue-based reference model, negedge monitor.
module tb_ex_writeback_arbiter;
  import ex_writeback_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic wb_ready = 1'b0;
  ex_update [N-1:0] fu_update = '0;
  logic [N-1:0]     fu_stall;
  ex_update [1:0]   wb_update;
  logic [CW-1:0]    perf_conflict_cnt;
  logic [CW-1:0]    perf_stall_cnt;

  always #5 clk = ~clk;

  ex_writeback_arbiter #(.FU_NUMBER(N), .DEPTH(D), .WB_PORTS(2), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .fu_update         (fu_update),
    .fu_stall          (fu_stall),
    .wb_update         (wb_update),
    .wb_ready          (wb_ready),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned seq      = 0;

  // Reference model: per-FU pending queues (arrival included), presented outputs, rr pointer.
  ex_update    mq [N][$];
  ex_update    exp_q [2][$];
  bit          m_out_v [2];
  int unsigned m_rr;
  longint unsigned m_conf;
  longint unsigned m_stall;
  int unsigned xfer_cnt [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ex_update make_rec(input int unsigned fu);
    ex_update r;
    r.valid   = 1'b1;
    r.rob_tag = {fu[1:0], seq[3:0]};
    r.data    = $urandom;
    seq++;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    for (int p = 0; p < 2; p++) begin
      exp_q[p].delete();
      m_out_v[p] = 1'b0;
    end
    m_rr    = 0;
    m_conf  = 0;
    m_stall = 0;
  endtask

  task automatic model_step();
    int unsigned cand = 0;
    bit          st   = 1'b0;
    int unsigned got  = 0;
    int unsigned last = 0;
    for (int i = 0; i < N; i++) begin
      if (mq[i].size() > 0 || fu_update[i].valid) cand++;
      if (mq[i].size() == D) st = 1'b1;
    end
    if (cand > 2 && m_conf != 64'hFFFF_FFFF) m_conf++;
    if (st && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      for (int p = 0; p < 2; p++) begin
        exp_q[p].delete();
        m_out_v[p] = 1'b0;
      end
      m_rr = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (fu_update[i].valid) mq[i].push_back(fu_update[i]);
    if (wb_ready || !(m_out_v[0] || m_out_v[1])) begin
      m_out_v[0] = 1'b0;
      m_out_v[1] = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        int unsigned i;
        i = (m_rr + k) % N;
        if (got < 2 && mq[i].size() > 0) begin
          exp_q[got].push_back(mq[i].pop_front());
          m_out_v[got] = 1'b1;
          last = i;
          got++;
        end
      end
      if (got > 0) m_rr = (last + 1) % N;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin : monitor
    ex_update e;
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("wb%0d_valid", p), 64'(wb_update[p].valid), 64'(m_out_v[p]));
        if (wb_update[p].valid && wb_ready) begin
          if (exp_q[p].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb%0d_unexpected: got %0h expected no record at %0t", p, wb_update[p], $time);
          end else begin
            e = exp_q[p].pop_front();
            chk($sformatf("wb%0d_record", p), 64'(wb_update[p]), 64'(e));
            xfer_cnt[e.rob_tag[5:4]]++;
          end
        end
      end
      for (int i = 0; i < N; i++)
        chk($sformatf("fu_stall%0d", i), 64'(fu_stall[i]), 64'(mq[i].size() == D));
`ifdef WB_PERF_CNT_EN
      chk("perf_conflict", 64'(perf_conflict_cnt), m_conf);
      chk("perf_stall", 64'(perf_stall_cnt), m_stall);
`else
      chk("perf_conflict", 64'(perf_conflict_cnt), 64'(0));
      chk("perf_stall", 64'(perf_stall_cnt), 64'(0));
`endif
    end
  end

  task automatic drive(input logic [N-1:0] vmask, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    wb_ready = rdy;
    flush    = fl;
    for (int i = 0; i < N; i++)
      if (vmask[i] && mq[i].size() != D) fu_update[i] = make_rec(i);
      else                               fu_update[i] = '0;
  endtask

  ex_update r0, r1, r2, r3;
  int unsigned base0, base3;

  initial begin
    for (int i = 0; i < N; i++) xfer_cnt[i] = 0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_wb0", 64'(wb_update[0]), 64'(0));
    chk("reset_wb1", 64'(wb_update[1]), 64'(0));
    chk("reset_stall", 64'(fu_stall), 64'(0));
    chk("reset_perf", 64'(perf_conflict_cnt | perf_stall_cnt), 64'(0));

    // single INT result: one-cycle latency
    drive(4'b0100, 1'b1, 1'b0);
    r0 = fu_update[2];
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_wb0", 64'(wb_update[0]), 64'(r0));
    chk("t1_wb1_valid", 64'(wb_update[1].valid), 64'(0));
    chk("t1_stall", 64'(fu_stall), 64'(0));

    // four-way burst from rr_ptr=0
    drive(4'b0000, 1'b1, 1'b1);
    drive(4'b1111, 1'b1, 1'b0);
    r0 = fu_update[0]; r1 = fu_update[1]; r2 = fu_update[2]; r3 = fu_update[3];
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_c1_wb0", 64'(wb_update[0]), 64'(r0));
    chk("t2_c1_wb1", 64'(wb_update[1]), 64'(r1));
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_c2_wb0", 64'(wb_update[0]), 64'(r2));
    chk("t2_c2_wb1", 64'(wb_update[1]), 64'(r3));
`ifdef WB_PERF_CNT_EN
    chk("t2_conflict", 64'(perf_conflict_cnt), 64'(1));
`else
    chk("t2_conflict", 64'(perf_conflict_cnt), 64'(0));
`endif

    // backpressure on FPU
    drive(4'b0010, 1'b0, 1'b0);
    r0 = fu_update[1];
    drive(4'b0010, 1'b0, 1'b0);
    r1 = fu_update[1];
    drive(4'b0010, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_stall_full", 64'(fu_stall[1]), 64'(1));
    chk("t3_hold_wb0", 64'(wb_update[0]), 64'(r0));
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_second_wb0", 64'(wb_update[0]), 64'(r1));
    chk("t3_stall_drop", 64'(fu_stall[1]), 64'(0));
    repeat (3) drive(4'b0000, 1'b1, 1'b0);

    // fairness between LSU and BRANCH
    base0 = xfer_cnt[0];
    base3 = xfer_cnt[3];
    repeat (100) drive(4'b1001, 1'b1, 1'b0);
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    chk("t4_lsu_xfers", 64'(xfer_cnt[0] - base0), 64'(100));
    chk("t4_br_xfers", 64'(xfer_cnt[3] - base3), 64'(100));

    // flush with INT buffered and a concurrent LSU push
    repeat (3) drive(4'b0100, 1'b0, 1'b0);
    drive(4'b0001, 1'b0, 1'b1);
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_wb_valid", 64'({wb_update[1].valid, wb_update[0].valid}), 64'(0));
    chk("t5_stall", 64'(fu_stall), 64'(0));
    repeat (5) drive(4'b0000, 1'b1, 1'b0);

    // randomized traffic with occasional flushes
    repeat (1500) drive(4'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0);
    repeat (4) drive(4'b0000, 1'b1, 1'b0);

    // async reset with every FIFO full
    repeat (4) drive(4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_all_full", 64'(fu_stall), 64'hF);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    fu_update = '0;
    flush     = 1'b0;
    wb_ready  = 1'b1;
    #1;
    chk("t6_rst_wb0", 64'(wb_update[0]), 64'(0));
    chk("t6_rst_wb1", 64'(wb_update[1]), 64'(0));
    chk("t6_rst_stall", 64'(fu_stall), 64'(0));
    chk("t6_rst_perf", 64'(perf_conflict_cnt | perf_stall_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    r0 = fu_update[1];
    drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_new_wb0", 64'(wb_update[0]), 64'(r0));

    repeat (5) drive(4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_q0", 64'(exp_q[0].size()), 64'(0));
    chk("drain_q1", 64'(exp_q[1].size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
